// File: rtl/csit_luks_pkg.sv
// Shared types and defaults for the tt_um_csit_luks SPI bus arbitration logic.
package csit_luks_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FLASH = 2'b01,
    OWN_SENS  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT_FLASH,
    ST_GNT_SENS,
    ST_GAP
  } arb_state_e;

  localparam int unsigned DEF_GAP_CYCLES     = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_cycle_timer.sv
// Loadable up/down cycle counter with a terminal-count flag against a supplied value.
module arb_cycle_timer #(
  parameter int unsigned WIDTH    = 1,
  parameter bit          COUNT_UP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = COUNT_UP ? (count_q + 1'b1) : (count_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI pins between the flash boot reader and the
// sensor reader, with a CS guard gap between owners and a grant watchdog.
module spi_bus_arbiter
  import csit_luks_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_req,
  output logic       flash_gnt,
  input  logic       flash_sclk,
  input  logic       flash_cs_n,
  input  logic       flash_mosi,
  input  logic       sens_req,
  output logic       sens_gnt,
  input  logic       sens_sclk,
  input  logic       sens_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       flash_cs_o,
  output logic       sens_cs_o,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned WD_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
  localparam bit WD_ON  = (TIMEOUT_CYCLES > 0);
  localparam bit GAP_ON = (GAP_CYCLES > 0);
  localparam logic [WD_W-1:0]  WD_TERM  = WD_ON  ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_ON ? GAP_W'(GAP_CYCLES - 1)    : '0;
  localparam arb_state_e REL_STATE = GAP_ON ? ST_GAP : ST_IDLE;

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     last_owner_q, last_owner_d;
  logic       flash_gnt_q, flash_gnt_d;
  logic       sens_gnt_q, sens_gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_err_q, timeout_err_d;
  logic       lock_flash_q, lock_flash_d;
  logic       lock_sens_q, lock_sens_d;

  logic wd_load, wd_en, wd_tc;
  logic gap_load, gap_en, gap_tc;
  logic flash_elig, sens_elig;
  logic flash_rel, sens_rel;

  arb_cycle_timer #(
    .WIDTH    (WD_W),
    .COUNT_UP (1'b1)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val ('0),
    .en       (wd_en),
    .tc_val   (WD_TERM),
    .tc       (wd_tc)
  );

  arb_cycle_timer #(
    .WIDTH    (GAP_W),
    .COUNT_UP (1'b0)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .tc_val   ('0),
    .tc       (gap_tc)
  );

  assign flash_elig = flash_req && !lock_flash_q;
  assign sens_elig  = sens_req && !lock_sens_q;
  assign wd_en      = (state_q == ST_GNT_FLASH) || (state_q == ST_GNT_SENS);
  assign gap_en     = (state_q == ST_GAP);
  assign flash_rel  = !flash_req || (WD_ON && wd_tc);
  assign sens_rel   = !sens_req || (WD_ON && wd_tc);

  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    timeout_err_d = 1'b0;
    lock_flash_d  = flash_req ? lock_flash_q : 1'b0;
    lock_sens_d   = sens_req ? lock_sens_q : 1'b0;
    wd_load       = 1'b0;
    gap_load      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (flash_elig && (!sens_elig || last_owner_q == OWN_SENS)) begin
          state_d      = ST_GNT_FLASH;
          last_owner_d = OWN_FLASH;
          wd_load      = 1'b1;
        end else if (sens_elig) begin
          state_d      = ST_GNT_SENS;
          last_owner_d = OWN_SENS;
          wd_load      = 1'b1;
        end
      end
      ST_GNT_FLASH: begin
        if (flash_rel) begin
          state_d  = REL_STATE;
          gap_load = GAP_ON;
          // A watchdog release only happens with req still high.
          if (flash_req) begin
            timeout_err_d = 1'b1;
            lock_flash_d  = 1'b1;
          end
        end
      end
      ST_GNT_SENS: begin
        if (sens_rel) begin
          state_d  = REL_STATE;
          gap_load = GAP_ON;
          if (sens_req) begin
            timeout_err_d = 1'b1;
            lock_sens_d   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    flash_gnt_d = (state_d == ST_GNT_FLASH);
    sens_gnt_d  = (state_d == ST_GNT_SENS);
    busy_d      = (state_d != ST_IDLE);
    owner_d     = flash_gnt_d ? OWN_FLASH : (sens_gnt_d ? OWN_SENS : OWN_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_NONE;
      last_owner_q  <= OWN_SENS;
      flash_gnt_q   <= 1'b0;
      sens_gnt_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      lock_flash_q  <= 1'b0;
      lock_sens_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      flash_gnt_q   <= flash_gnt_d;
      sens_gnt_q    <= sens_gnt_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      lock_flash_q  <= lock_flash_d;
      lock_sens_q   <= lock_sens_d;
    end
  end

  always_comb begin
    spi_sclk   = 1'b0;
    spi_mosi   = 1'b0;
    flash_cs_o = 1'b1;
    sens_cs_o  = 1'b1;
    unique case (owner_q)
      OWN_FLASH: begin
        spi_sclk   = flash_sclk;
        spi_mosi   = flash_mosi;
        flash_cs_o = flash_cs_n;
      end
      OWN_SENS: begin
        spi_sclk  = sens_sclk;
        sens_cs_o = sens_cs_n;
      end
      default: begin
        spi_sclk = 1'b0;
      end
    endcase
  end

  assign flash_gnt   = flash_gnt_q;
  assign sens_gnt    = sens_gnt_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected ownership events, per-DUT monitors check them.
module tb_spi_bus_arbiter;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_FLASH = 2'b01;
  localparam logic [1:0] E_SENS  = 2'b10;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  own;
    logic        fg;
    logic        sg;
    logic        to;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  evt_t qa[$];
  evt_t qb[$];
  evt_t ea, eb;
  bit   mon_en = 1'b0;

  // DUT A: gap 2, watchdog 8
  logic a_rst, a_flash_req, a_flash_sclk, a_flash_cs_n, a_flash_mosi;
  logic a_sens_req, a_sens_sclk, a_sens_cs_n;
  logic a_flash_gnt, a_sens_gnt, a_spi_sclk, a_spi_mosi, a_flash_cs_o, a_sens_cs_o;
  logic a_busy, a_timeout_err;
  logic [1:0] a_owner;

  // DUT B: no gap, watchdog disabled
  logic b_rst, b_flash_req, b_flash_sclk, b_flash_cs_n, b_flash_mosi;
  logic b_sens_req, b_sens_sclk, b_sens_cs_n;
  logic b_flash_gnt, b_sens_gnt, b_spi_sclk, b_spi_mosi, b_flash_cs_o, b_sens_cs_o;
  logic b_busy, b_timeout_err;
  logic [1:0] b_owner;

  spi_bus_arbiter #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .flash_req(a_flash_req), .flash_gnt(a_flash_gnt),
    .flash_sclk(a_flash_sclk), .flash_cs_n(a_flash_cs_n), .flash_mosi(a_flash_mosi),
    .sens_req(a_sens_req), .sens_gnt(a_sens_gnt),
    .sens_sclk(a_sens_sclk), .sens_cs_n(a_sens_cs_n),
    .spi_sclk(a_spi_sclk), .spi_mosi(a_spi_mosi),
    .flash_cs_o(a_flash_cs_o), .sens_cs_o(a_sens_cs_o),
    .owner(a_owner), .busy(a_busy), .timeout_err(a_timeout_err)
  );

  spi_bus_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .flash_req(b_flash_req), .flash_gnt(b_flash_gnt),
    .flash_sclk(b_flash_sclk), .flash_cs_n(b_flash_cs_n), .flash_mosi(b_flash_mosi),
    .sens_req(b_sens_req), .sens_gnt(b_sens_gnt),
    .sens_sclk(b_sens_sclk), .sens_cs_n(b_sens_cs_n),
    .spi_sclk(b_spi_sclk), .spi_mosi(b_spi_mosi),
    .flash_cs_o(b_flash_cs_o), .sens_cs_o(b_sens_cs_o),
    .owner(b_owner), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  task automatic push(input bit to_b, input int unsigned c, input logic [1:0] own, input logic to);
    evt_t e;
    e.cyc = c;
    e.own = own;
    e.fg  = (own == E_FLASH);
    e.sg  = (own == E_SENS);
    e.to  = to;
    if (to_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic score(input string tag, input bit have, input evt_t e, input int unsigned c,
                       input logic [1:0] own, input logic fg, input logic sg, input logic to);
    checks++;
    if (!have)
      $display("FAIL %s_unexpected: got cyc=%0d own=%b fgnt=%b sgnt=%b to=%b, required no event", tag, c, own, fg, sg, to);
    else if (e.cyc == c && e.own === own && e.fg === fg && e.sg === sg && e.to === to)
      passed++;
    else
      $display("FAIL %s_event: got cyc=%0d own=%b fgnt=%b sgnt=%b to=%b, required cyc=%0d own=%b fgnt=%b sgnt=%b to=%b",
               tag, c, own, fg, sg, to, e.cyc, e.own, e.fg, e.sg, e.to);
  endtask

  logic [1:0] a_prev_own = 2'b00, b_prev_own = 2'b00;
  logic a_prev_fg = 1'b0, a_prev_sg = 1'b0, b_prev_fg = 1'b0, b_prev_sg = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_owner !== a_prev_own || a_flash_gnt !== a_prev_fg || a_sens_gnt !== a_prev_sg || a_timeout_err !== 1'b0) begin
        bit have;
        have = (qa.size() > 0);
        if (have) ea = qa.pop_front();
        score("a", have, ea, cyc, a_owner, a_flash_gnt, a_sens_gnt, a_timeout_err);
        a_prev_own = a_owner;
        a_prev_fg  = a_flash_gnt;
        a_prev_sg  = a_sens_gnt;
      end
      if (b_owner !== b_prev_own || b_flash_gnt !== b_prev_fg || b_sens_gnt !== b_prev_sg || b_timeout_err !== 1'b0) begin
        bit have;
        have = (qb.size() > 0);
        if (have) eb = qb.pop_front();
        score("b", have, eb, cyc, b_owner, b_flash_gnt, b_sens_gnt, b_timeout_err);
        b_prev_own = b_owner;
        b_prev_fg  = b_flash_gnt;
        b_prev_sg  = b_sens_gnt;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int unsigned c, g;
    bit cur_sens;

    a_rst = 1'b1; b_rst = 1'b1;
    a_flash_req = 1'b0; a_sens_req = 1'b0; b_flash_req = 1'b0; b_sens_req = 1'b0;
    a_flash_sclk = 1'b1; a_flash_cs_n = 1'b0; a_flash_mosi = 1'b1;
    a_sens_sclk = 1'b1; a_sens_cs_n = 1'b0;
    b_flash_sclk = 1'b0; b_flash_cs_n = 1'b1; b_flash_mosi = 1'b0;
    b_sens_sclk = 1'b0; b_sens_cs_n = 1'b1;

    step(3);
    check("rst_owner", a_owner, E_NONE);
    check("rst_gnts", {a_flash_gnt, a_sens_gnt}, 2'b00);
    check("rst_busy_to", {a_busy, a_timeout_err}, 2'b00);
    check("rst_pins", {a_spi_sclk, a_spi_mosi, a_flash_cs_o, a_sens_cs_o}, 4'b0011);
    check("b_rst_state", {b_owner, b_flash_gnt, b_sens_gnt, b_busy, b_timeout_err}, 6'b000000);

    // Tie right after reset: flash wins, then releases and the sensor follows after the gap.
    a_rst = 1'b0; b_rst = 1'b0; mon_en = 1'b1;
    a_flash_sclk = 1'b0; a_flash_cs_n = 1'b1; a_flash_mosi = 1'b0;
    a_sens_sclk = 1'b0; a_sens_cs_n = 1'b1;
    c = cyc;
    a_flash_req = 1'b1; a_sens_req = 1'b1;
    push(0, c + 1, E_FLASH, 1'b0);
    step(1);
    check("flash_busy", a_busy, 1'b1);
    a_flash_cs_n = 1'b0; a_flash_mosi = 1'b1; a_flash_sclk = 1'b1;
    a_sens_sclk = 1'b1; a_sens_cs_n = 1'b0;
    #1;
    check("flash_pins_hi", {a_spi_sclk, a_spi_mosi, a_flash_cs_o, a_sens_cs_o}, 4'b1101);
    a_flash_sclk = 1'b0;
    #1;
    check("flash_sclk_lo", a_spi_sclk, 1'b0);
    step(1);
    c = cyc;
    a_flash_req = 1'b0; a_flash_cs_n = 1'b1; a_flash_sclk = 1'b1;
    push(0, c + 1, E_NONE, 1'b0);
    push(0, c + 4, E_SENS, 1'b0);
    step(1);
    #1;
    check("gap_pins", {a_spi_sclk, a_flash_cs_o, a_sens_cs_o}, 3'b011);
    check("gap_busy", {a_busy, a_flash_gnt, a_sens_gnt}, 3'b100);
    wait_cyc(c + 4);
    #1;
    check("sens_pins", {a_spi_sclk, a_spi_mosi, a_flash_cs_o, a_sens_cs_o}, 4'b1010);
    a_flash_sclk = 1'b0; a_flash_mosi = 1'b0;

    // Held sensor request: watchdog revokes after 8 cycles, then lockout until req drops.
    g = c + 4;
    push(0, g + 8, E_NONE, 1'b1);
    wait_cyc(g + 8);
    check("wd_pulse", a_timeout_err, 1'b1);
    step(1);
    check("wd_pulse_end", a_timeout_err, 1'b0);
    wait_cyc(g + 12);
    check("lockout", {a_sens_gnt, a_busy}, 2'b00);
    a_sens_req = 1'b0; a_sens_cs_n = 1'b1; a_sens_sclk = 1'b0;
    step(1);
    c = cyc;
    a_sens_req = 1'b1;
    push(0, c + 1, E_SENS, 1'b0);
    step(3);
    c = cyc;
    a_sens_req = 1'b0;
    push(0, c + 1, E_NONE, 1'b0);
    wait_cyc(c + 5);

    // Ten alternating transactions with both masters requesting continuously.
    c = cyc;
    a_flash_req = 1'b1; a_sens_req = 1'b1;
    push(0, c + 1, E_FLASH, 1'b0);
    g = c + 1;
    cur_sens = 1'b0;
    for (int t = 0; t < 10; t++) begin
      wait_cyc(g + 2);
      if (t == 9) begin
        a_flash_req = 1'b0; a_sens_req = 1'b0;
      end else if (cur_sens) a_sens_req = 1'b0;
      else a_flash_req = 1'b0;
      push(0, g + 3, E_NONE, 1'b0);
      if (t < 9) push(0, g + 6, cur_sens ? E_FLASH : E_SENS, 1'b0);
      step(1);
      if (t < 9) begin
        if (cur_sens) a_sens_req = 1'b1;
        else a_flash_req = 1'b1;
      end
      g = g + 6;
      cur_sens = !cur_sens;
    end

    // Reset mid flash transfer: immediate release, no gap, flash wins the next tie again.
    wait_cyc(g);
    c = cyc;
    a_flash_req = 1'b1;
    push(0, c + 1, E_FLASH, 1'b0);
    step(2);
    a_flash_cs_n = 1'b0; a_flash_sclk = 1'b1;
    a_rst = 1'b1;
    push(0, c + 3, E_NONE, 1'b0);
    step(1);
    #1;
    check("rst_mid_pins", {a_spi_sclk, a_flash_cs_o, a_sens_cs_o}, 3'b011);
    check("rst_mid_state", {a_owner, a_flash_gnt, a_busy}, 4'b0000);
    a_rst = 1'b0; a_sens_req = 1'b1;
    push(0, c + 4, E_FLASH, 1'b0);
    step(1);
    #1;
    check("regrant_cs", {a_flash_cs_o, a_sens_cs_o}, 2'b01);
    step(1);
    a_flash_req = 1'b0; a_sens_req = 1'b0;
    a_flash_cs_n = 1'b1; a_flash_sclk = 1'b0;
    push(0, c + 6, E_NONE, 1'b0);
    step(3);

    // DUT B: masking while ungranted, one-cycle handover with no gap, no watchdog.
    for (int i = 0; i < 3; i++) begin
      b_sens_sclk = 1'b1; b_sens_cs_n = 1'b0;
      #1;
      check("b_mask_idle", {b_spi_sclk, b_sens_cs_o}, 2'b01);
      step(1);
      b_sens_sclk = 1'b0; b_sens_cs_n = 1'b1;
    end
    c = cyc;
    b_flash_req = 1'b1; b_sens_req = 1'b1;
    push(1, c + 1, E_FLASH, 1'b0);
    step(2);
    b_sens_sclk = 1'b1; b_sens_cs_n = 1'b0;
    #1;
    check("b_mask_other", {b_spi_sclk, b_flash_cs_o, b_sens_cs_o}, 3'b011);
    wait_cyc(c + 12);
    b_flash_req = 1'b0;
    push(1, c + 13, E_NONE, 1'b0);
    push(1, c + 14, E_SENS, 1'b0);
    wait_cyc(c + 14);
    #1;
    check("b_sens_pins", {b_spi_sclk, b_flash_cs_o, b_sens_cs_o}, 3'b110);
    wait_cyc(c + 34);
    b_sens_req = 1'b0; b_sens_sclk = 1'b0; b_sens_cs_n = 1'b1;
    push(1, c + 35, E_NONE, 1'b0);
    step(5);

    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
